// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forward selects, writeback
// selects and the sequencing FSM states.
package hazard_ctrl_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2
  } hz_state_t;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Execute-stage operand forwarding comparator for one source register.
// M beats W; x0 is never forwarded.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rdM,
  input  logic       i_regwriteM,
  input  logic [4:0] i_rdW,
  input  logic       i_regwriteW,
  output logic [1:0] o_fwd
);
  always_comb begin
    o_fwd = FWD_RF;
    if (i_regwriteM && (i_rdM != 5'd0) && (i_rdM == i_rs))
      o_fwd = FWD_M;
    else if (i_regwriteW && (i_rdW != 5'd0) && (i_rdW == i_rs))
      o_fwd = FWD_W;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: forwarding, stall/flush, priming and
// memory-wait timeout. Define HAZ_PERF_CNT_EN to build the stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rs1E,
  input  logic [4:0]  rs2E,
  input  logic [4:0]  rdE,
  input  logic        regwriteE,
  input  logic [1:0]  wbselE,
  input  logic [4:0]  rdM,
  input  logic        regwriteM,
  input  logic [4:0]  rdW,
  input  logic        regwriteW,
  input  logic        pcselE,
  input  logic        mem_reqM,
  input  logic        mem_readyM,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        flushD,
  output logic        flushE,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  localparam int PW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  hz_state_t        r_state;
  logic [CNT_W-1:0] r_wcnt;
  logic [PW-1:0]    r_pcnt;
  logic             r_timeout;

  logic [1:0]       w_fwdA, w_fwdB;
  logic             w_prime, w_prime_last, w_mem_wait, w_lu;
  logic [CNT_W-1:0] w_wnext;

  fwd_sel u_fwd_a (.i_rs(rs1E), .i_rdM(rdM), .i_regwriteM(regwriteM),
                   .i_rdW(rdW), .i_regwriteW(regwriteW), .o_fwd(w_fwdA));
  fwd_sel u_fwd_b (.i_rs(rs2E), .i_rdM(rdM), .i_regwriteM(regwriteM),
                   .i_rdW(rdW), .i_regwriteW(regwriteW), .o_fwd(w_fwdB));

  assign forwardAE = rst_n ? w_fwdA : FWD_RF;
  assign forwardBE = rst_n ? w_fwdB : FWD_RF;

  assign w_prime      = (r_state == ST_PRIME);
  assign w_prime_last = (INIT_CYCLES <= 1) || (r_pcnt == PW'(INIT_CYCLES - 1));
  assign w_mem_wait   = mem_reqM && !mem_readyM;
  // Link results (pc+4) also need a stall: M only forwards the ALU result.
  assign w_lu = regwriteE && (rdE != 5'd0) && (wbselE != WB_ALU) &&
                ((rdE == rs1D) || (rdE == rs2D));

  // First wait cycle seeds the count at 1; afterwards it saturates.
  assign w_wnext = (r_state != ST_WAIT) ? CNT_W'(1) :
                   (r_wcnt == CNT_W'(MEM_TIMEOUT)) ? r_wcnt : r_wcnt + 1'b1;

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (w_prime) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end else if (w_mem_wait) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (pcselE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (w_lu) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_PRIME;
      r_wcnt    <= '0;
      r_pcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_PRIME: begin
          if (w_prime_last) begin
            r_state <= ST_RUN;
            r_pcnt  <= '0;
          end else begin
            r_pcnt  <= r_pcnt + 1'b1;
          end
        end
        ST_RUN, ST_WAIT: begin
          if (w_mem_wait) begin
            r_state <= ST_WAIT;
            r_wcnt  <= w_wnext;
            if (w_wnext == CNT_W'(MEM_TIMEOUT)) r_timeout <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_wcnt  <= '0;
          end
        end
        default: r_state <= ST_PRIME;
      endcase
    end
  end

  assign mem_timeout = r_timeout;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stallF || stallD || stallE || stallM) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (pcselE && !w_mem_wait)                r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a cycle-level
// behavioural model of the pipeline sequencing rules.
module tb_hazard_ctrl;
  localparam int INIT = 4;
  localparam int MTO  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       regwriteE, regwriteM, regwriteW, pcselE, mem_reqM, mem_readyM;
  logic [1:0] wbselE;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.INIT_CYCLES(INIT), .MEM_TIMEOUT(MTO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .regwriteE(regwriteE), .wbselE(wbselE), .rdM(rdM), .regwriteM(regwriteM),
    .rdW(rdW), .regwriteW(regwriteW), .pcselE(pcselE),
    .mem_reqM(mem_reqM), .mem_readyM(mem_readyM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state: priming cycles left, consecutive wait cycles, sticky timeout
  int          m_prime;
  int          m_run;
  bit          m_to;
  logic [31:0] m_scnt, m_fcnt;
  bit          e_any_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (!rst_n)                                return 2'b00;
    if (regwriteM && rdM != 0 && rdM == rs)    return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs)    return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_outs();
    bit pr, mw, lu;
    logic [3:0] st;
    logic [1:0] fl;
    pr = !rst_n || (m_prime > 0);
    mw = mem_reqM && !mem_readyM;
    lu = regwriteE && rdE != 0 && wbselE != 2'b00 && (rdE == rs1D || rdE == rs2D);
    st = 4'b0000;
    fl = 2'b00;
    if (pr)          begin st = 4'b0001; fl = 2'b10; end
    else if (mw)     st = 4'b1111;
    else if (pcselE) fl = 2'b11;
    else if (lu)     begin st = 4'b0011; fl = 2'b01; end
    e_any_stall = (st != 0);
    chk("stall_MEDF", {28'd0, stallM, stallE, stallD, stallF}, {28'd0, st});
    chk("flush_DE",   {30'd0, flushD, flushE}, {30'd0, fl});
    chk("forwardAE",  {30'd0, forwardAE}, {30'd0, fwd_ref(rs1E)});
    chk("forwardBE",  {30'd0, forwardBE}, {30'd0, fwd_ref(rs2E)});
    chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
    chk("stall_cnt",  stall_cnt, m_scnt);
    chk("flush_cnt",  flush_cnt, m_fcnt);
  endtask

  task automatic model_reset();
    m_prime = (INIT > 0) ? INIT : 1;
    m_run   = 0;
    m_to    = 1'b0;
    m_scnt  = '0;
    m_fcnt  = '0;
  endtask

  // called at a negedge with inputs settled; leaves at the next negedge
  task automatic step();
    bit mw;
    #1 check_outs();
    mw = mem_reqM && !mem_readyM;
    @(posedge clk);
    if (rst_n) begin
`ifdef HAZ_PERF_CNT_EN
      if (e_any_stall)      m_scnt++;
      if (pcselE && !mw)    m_fcnt++;
`endif
      if (m_prime > 0) m_prime--;
      else if (mw) begin
        if (m_run < MTO) m_run++;
        if (m_run >= MTO) m_to = 1'b1;
      end else m_run = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {regwriteE, regwriteM, regwriteW, pcselE, mem_reqM, mem_readyM} = '0;
    wbselE = 2'b00;
  endtask

  task automatic rand_in();
    rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
    rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
    rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
    rdW  = 5'($urandom_range(0, 3));
    regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
    wbselE = 2'($urandom_range(0, 3));
    pcselE = ($urandom_range(0, 3) == 0);
    mem_reqM = ($urandom_range(0, 2) == 0);
    mem_readyM = 1'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1 check_outs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_in();
    // forwarding-looking inputs during reset must still read 00
    rs1E = 5'd5; rdM = 5'd5; regwriteM = 1'b1;
    do_reset();

    // priming: fetch held and D flushed for INIT cycles, then quiet
    idle_in();
    for (int i = 0; i < INIT + 2; i++) step();

    // forwarding priority and x0
    rs1E = 5'd5; rdM = 5'd5; regwriteM = 1'b1; rdW = 5'd5; regwriteW = 1'b1;
    rs2E = 5'd5;
    step();
    chk("fwdA_M", {30'd0, forwardAE}, 32'd2);
    rdM = 5'd0;
    step();
    chk("fwdA_W", {30'd0, forwardAE}, 32'd1);
    rs1E = 5'd0; rdW = 5'd0;
    step();
    chk("fwdA_x0", {30'd0, forwardAE}, 32'd0);

    // load-use: one stall, then bubble in E
    idle_in();
    regwriteE = 1'b1; wbselE = 2'b01; rdE = 5'd7; rs2D = 5'd7;
    #1 chk("lu_stallF", {31'd0, stallF}, 32'd1);
    step();
    regwriteE = 1'b0; wbselE = 2'b00; rdE = 5'd0;
    step();

    // taken branch overrides load-use
    regwriteE = 1'b1; wbselE = 2'b10; rdE = 5'd7; rs2D = 5'd7; pcselE = 1'b1;
    #1 chk("br_stallF", {31'd0, stallF}, 32'd0);
    step();
    idle_in();
    step();

    // memory wait for 3 cycles with a pending branch, then ready
    mem_reqM = 1'b1; pcselE = 1'b1;
    for (int i = 0; i < 3; i++) step();
    mem_readyM = 1'b1;
    step();
    idle_in();
    step();

    for (int i = 0; i < 300; i++) begin
      rand_in();
      step();
    end

    // timeout: 6 wait cycles, sticky past ready, cleared by async reset mid-wait
    idle_in();
    do_reset();
    for (int i = 0; i < INIT; i++) step();
    mem_reqM = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("to_set", {31'd0, mem_timeout}, 32'd1);
    mem_readyM = 1'b1;
    step();
    idle_in();
    step();
    chk("to_sticky", {31'd0, mem_timeout}, 32'd1);
    mem_reqM = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outs();
    chk("to_async_clr", {31'd0, mem_timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_in();
    for (int i = 0; i < 40; i++) begin
      if (i >= INIT) rand_in();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
